piso4b_tx: RTL and testbench
============================

// Module: piso4b_tx
// PURPOSE
//   Parallel-in/serial-out transmitter for the 4-bit register datapath: captures a parallel word on a
//   load request and drives it out one bit per clock with a valid strobe and an end-of-frame pulse.
//   It is the serial output end for a loaded register word. It sits between a 4-bit register stage
//   and a single-wire serial sink.
// PARAMETERS
//   WIDTH      4   data word width in bits (>= 2)
//   MSB_FIRST  1   1: shift out d[WIDTH-1] first; 0: shift out d[0] first
// PORTS
//   clk         in   1      system clock, rising-edge active
//   clr         in   1      asynchronous, active-high reset; clears all state immediately
//   ld          in   1      load request; accepted only when busy=0
//   d           in   WIDTH  parallel word, sampled only on the accepting edge
//   busy        out  1      1 while a frame is in flight (SHIFT or PARITY state)
//   sout        out  1      serial data bit; 0 whenever sout_valid=0
//   sout_valid  out  1      1 on every cycle that sout carries a frame bit
//   done        out  1      one-cycle pulse after the last frame bit
// BEHAVIOUR
// - Reset (clr=1, asynchronous): state=IDLE, shift reg=0, bit counter=0; busy=sout=sout_valid=done=0.
//   Asserting clr mid-frame aborts the frame: no further bits, no done pulse.
// - Outputs are Moore outputs decoded from registered state; no combinational path from ld/d to outputs.
// - States: IDLE, SHIFT, PARITY (present only with the macro), DONE.
//   IDLE:   busy=0, sout_valid=0, done=0. If ld=1 at a rising edge: capture d into shift reg,
//           counter=0, go to SHIFT. Otherwise stay in IDLE.
//   SHIFT:  busy=1, sout_valid=1, sout = shift reg[WIDTH-1] when MSB_FIRST=1, else shift reg[0].
//           Each edge: shift toward the output end (zero fill), counter+1.
//           At the edge where counter==WIDTH-1: go to PARITY if enabled, else go to DONE.
//   PARITY: busy=1, sout_valid=1, sout = even-parity bit (XOR of the captured word); next edge -> DONE.
//   DONE:   busy=0, sout_valid=0, done=1 for exactly one cycle. Accepts ld like IDLE: ld=1 -> capture d,
//           go to SHIFT (back-to-back frames with exactly one gap cycle); else go to IDLE.
// - Latency: with ld accepted at edge N, bit 0 of the frame is on sout during cycle N+1.
//   The frame occupies cycles N+1..N+WIDTH, or N+WIDTH+1 with parity. done is asserted in the cycle after.
// - ld while busy=1 is ignored. It is not queued, and it does not disturb the shift reg or counter.
// - d changing while busy=1 has no effect. The captured word is held internally for the parity computation.
// - Counter width is $clog2(WIDTH)+1. The counter never wraps within a frame.
// CONFIGURATION
//   PISO_PARITY_EN defined:   PARITY state is compiled in. Each frame is WIDTH+1 bits; the last bit is even parity.
//   PISO_PARITY_EN undefined: no PARITY state and no parity logic. Each frame is exactly WIDTH bits.
// TESTING
// 1. clr=1 with random ld/d -> busy=sout=sout_valid=done=0. Release clr -> outputs stay 0 until ld.
// 2. MSB_FIRST=1, ld=1 with d=4'b1011 -> sout_valid=1 for 4 cycles, sout=1,0,1,1; done=1 in the next cycle, then idle.
// 3. MSB_FIRST=0, d=4'b1011 -> sout=1,1,0,1. Repeat with d=4'b0000 and d=4'b1111 to cover constant frames.
// 4. ld=1 with d=4'b0110 during SHIFT (after a frame of 4'b1001) -> frame continues 1,0,0,1; 0110 is never sent.
// 5. clr pulsed mid-cycle during the 2nd bit -> outputs drop to 0 asynchronously and no done pulse follows.
//    ld after release -> clean full frame.
// 6. ld held high with 4'b1100 then 4'b0011 -> two frames separated by exactly one done cycle.
//    With PISO_PARITY_EN and d=4'b1011: 5 bits 1,0,1,1,1 (parity=1), then done.

Source files
------------

// File: rtl/piso4b_tx_if.sv
// piso4b_tx_if: parallel load request/word in, serial bit stream with valid/done strobes out.
interface piso4b_tx_if #(parameter int WIDTH = 4) ();
   logic             ld;
   logic [WIDTH-1:0] d;
   logic             busy;
   logic             sout;
   logic             sout_valid;
   logic             done;
   modport master (output ld, d, input busy, sout, sout_valid, done);
   modport slave  (input ld, d, output busy, sout, sout_valid, done);
endinterface

// File: rtl/piso4b_tx.sv
// piso4b_tx: parallel-in/serial-out frame transmitter; define PISO_PARITY_EN to append an even-parity bit.
module piso4b_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic          clk,
   input logic          clr,
   piso4b_tx_if.slave   bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
`ifdef PISO_PARITY_EN
      PARITY,
`endif
      DONE
   } state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nx;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last;
   logic             out_bit;
   assign accept  = bus.ld && (state == IDLE || state == DONE);
   assign last    = cnt == CW'(WIDTH - 1);
   assign out_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   assign sr_nx   = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
   // state register
   always_ff @(posedge clk or posedge clr)
      if (clr) state <= IDLE;
      else     state <= state_nx;
   // next-state decode; ld is honoured only from IDLE or DONE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = accept ? SHIFT : IDLE;
`ifdef PISO_PARITY_EN
         SHIFT:      state_nx = last ? PARITY : SHIFT;
         PARITY:     state_nx = DONE;
`else
         SHIFT:      state_nx = last ? DONE : SHIFT;
`endif
         default:    state_nx = IDLE;
      endcase
   end
   // shift register and bit counter; untouched outside an accept or SHIFT
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (accept) begin
         sr  <= bus.d;
         cnt <= '0;
      end else if (state == SHIFT) begin
         sr  <= sr_nx;
         cnt <= cnt + CW'(1);
      end
`ifdef PISO_PARITY_EN
   logic par;
   // parity of the captured word, kept since the shift register is drained by the time it is sent
   always_ff @(posedge clk or posedge clr)
      if (clr)         par <= 1'b0;
      else if (accept) par <= ^bus.d;
   assign bus.busy       = state == SHIFT || state == PARITY;
   assign bus.sout       = state == SHIFT ? out_bit : state == PARITY ? par : 1'b0;
`else
   assign bus.busy       = state == SHIFT;
   assign bus.sout       = state == SHIFT ? out_bit : 1'b0;
`endif
   assign bus.sout_valid = bus.busy;
   assign bus.done       = state == DONE;
endmodule

// File: tb/tb_piso4b_tx.sv
// tb_piso4b_tx: directed frame vectors against MSB-first and LSB-first instances sharing clock and reset.
module tb_piso4b_tx;
   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;
   piso4b_tx_if #(.WIDTH(W)) bm ();
   piso4b_tx_if #(.WIDTH(W)) bl ();
   piso4b_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .clr(clr), .bus(bm.slave));
   piso4b_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .clr(clr), .bus(bl.slave));
   logic [3:0] om, ol;
   assign om = {bm.busy, bm.sout_valid, bm.sout, bm.done};
   assign ol = {bl.busy, bl.sout_valid, bl.sout, bl.done};
   int total = 0;
   int bad   = 0;
   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] sm;
      logic [W-1:0] sl;
      logic         p;
   } vec_t;
   vec_t tbl[8];

   task automatic drive(input logic l, input logic [W-1:0] v);
      bm.ld = l; bm.d = v;
      bl.ld = l; bl.d = v;
   endtask

   task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got {busy,valid,sout,done}=%b want %b", nm, a, e);
      end
   endtask

   task automatic bits(input string nm, input logic [W-1:0] sm, input logic [W-1:0] sl, input logic p,
                       input logic [7:0] ldmask, input logic [W-1:0] dv);
      for (int i = 0; i < FL; i++) begin
         logic bmx, blx;
         if (i < W) begin
            bmx = sm[W-1-i];
            blx = sl[W-1-i];
         end else begin
            bmx = p;
            blx = p;
         end
         drive(ldmask[i], dv);
         chk($sformatf("%s msb bit%0d", nm, i), om, {2'b11, bmx, 1'b0});
         chk($sformatf("%s lsb bit%0d", nm, i), ol, {2'b11, blx, 1'b0});
         @(negedge clk);
      end
   endtask

   task automatic tail(input string nm);
      drive(1'b0, '0);
      chk({nm, " msb done"}, om, 4'b0001);
      chk({nm, " lsb done"}, ol, 4'b0001);
      @(negedge clk);
      chk({nm, " msb idle"}, om, 4'b0000);
      chk({nm, " lsb idle"}, ol, 4'b0000);
   endtask

   task automatic frame(input vec_t v, input string nm);
      @(negedge clk);
      drive(1'b1, v.d);
      @(negedge clk);
      bits(nm, v.sm, v.sl, v.p, 8'h00, v.d);
      tail(nm);
   endtask

   initial begin
      tbl[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
      tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[2] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
      tbl[3] = '{4'b1001, 4'b1001, 4'b1001, 1'b0};
      tbl[4] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
      tbl[5] = '{4'b1100, 4'b1100, 4'b0011, 1'b0};
      tbl[6] = '{4'b0011, 4'b0011, 4'b1100, 1'b0};
      tbl[7] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), W'($urandom));
         @(negedge clk);
         chk("reset msb", om, 4'b0000);
         chk("reset lsb", ol, 4'b0000);
      end
      drive(1'b0, '0);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post-reset msb", om, 4'b0000);
         chk("post-reset lsb", ol, 4'b0000);
      end
      // table-driven single frames
      for (int k = 0; k < 8; k++) frame(tbl[k], $sformatf("vec%0d", k));
      // ld with a new word while shifting 1001 is ignored
      @(negedge clk);
      drive(1'b1, 4'b1001);
      @(negedge clk);
      bits("ld-busy", 4'b1001, 4'b1001, 1'b0, 8'hFE, 4'b0110);
      tail("ld-busy");
      // asynchronous clear during the second bit aborts the frame
      @(negedge clk);
      drive(1'b1, 4'b1011);
      @(negedge clk);
      drive(1'b0, 4'b1011);
      chk("abort msb bit0", om, 4'b1110);
      chk("abort lsb bit0", ol, 4'b1110);
      @(posedge clk);
      #2 clr = 1'b1;
      #1;
      chk("async clr msb", om, 4'b0000);
      chk("async clr lsb", ol, 4'b0000);
      #1 clr = 1'b0;
      for (int i = 0; i < FL + 2; i++) begin
         @(negedge clk);
         chk("no done msb", om, 4'b0000);
         chk("no done lsb", ol, 4'b0000);
      end
      frame(tbl[0], "after-clr");
      // ld held high: two frames with exactly one done cycle between them
      @(negedge clk);
      drive(1'b1, 4'b1100);
      @(negedge clk);
      bits("b2b f1", 4'b1100, 4'b0011, 1'b0, 8'hFF, 4'b0011);
      chk("b2b gap msb", om, 4'b0001);
      chk("b2b gap lsb", ol, 4'b0001);
      @(negedge clk);
      bits("b2b f2", 4'b0011, 4'b1100, 1'b0, 8'h00, 4'b0011);
      tail("b2b f2");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
